// File: rtl/qspi_rx_deserializer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | qspi_rx_deserializer: samples io0..io3 in 1/2/4-line modes and pushes 32-bit |
// | words to the read buffer over valid/ready.        Revision: 1.0              |
// +-----------------------------------------------------------------------------+
module qspi_rx_deserializer #(
  parameter int DATA_W  = 32,
  parameter int WORDS_W = 3
) (
  input  logic               h_clk,
  input  logic               h_rstn,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         io_mode,
  input  logic [WORDS_W-1:0] num_words_m1,
  input  logic               sample_en,
  input  logic [3:0]         io_in,
  output logic [DATA_W-1:0]  rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic               send_data,
  output logic               busy,
  output logic               done,
  output logic               overrun
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_SINGLE = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_DUAL   = CNT_W'(DATA_W / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_QUAD   = CNT_W'(DATA_W / 4 - 1);
  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_DUAL   = 2'b01;
  localparam logic [1:0] MODE_QUAD   = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [WORDS_W-1:0] words_q, words_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  sr_q, sr_d;
  logic [DATA_W-1:0]  rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               overrun_q, overrun_d;

  logic [DATA_W-1:0]  sr_shift;
  logic [CNT_W-1:0]   last_cnt;

  always_comb begin
    sr_shift = {sr_q[DATA_W-2:0], io_in[1]};
    last_cnt = LAST_SINGLE;
    case (mode_q)
      MODE_DUAL: begin
        sr_shift = {sr_q[DATA_W-3:0], io_in[1:0]};
        last_cnt = LAST_DUAL;
      end
      MODE_QUAD: begin
        sr_shift = {sr_q[DATA_W-5:0], io_in};
        last_cnt = LAST_QUAD;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    words_d    = words_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;

    // An accepted word frees the output slot unless a completion refills it below.
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d    = (io_mode == 2'b11) ? MODE_SINGLE : io_mode;
          words_d   = num_words_m1;
          overrun_d = 1'b0;
          cnt_d     = '0;
          sr_d      = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (sample_en) begin
          sr_d = sr_shift;
          if (cnt_q == last_cnt) begin
            cnt_d = '0;
            if (!rx_valid_q || rx_ready) begin
              rx_data_d  = sr_shift;
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
            if (words_q == '0) state_d = DRAIN;
            else               words_d = words_q - 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!rx_valid_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d    = IDLE;
      rx_valid_d = 1'b0;
      cnt_d      = '0;
      words_d    = '0;
      sr_d       = '0;
    end
  end

  always_ff @(posedge h_clk or negedge h_rstn) begin
    if (!h_rstn) begin
      state_q    <= IDLE;
      mode_q     <= MODE_SINGLE;
      words_q    <= '0;
      cnt_q      <= '0;
      sr_q       <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      words_q    <= words_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign send_data = (state_q == SHIFT);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DRAIN) && !rx_valid_q && !abort;

endmodule
`default_nettype wire

// File: tb/tb_qspi_rx_deserializer.sv
`default_nettype none
// Self-checking bench for qspi_rx_deserializer: scoreboard of expected words
// popped on each accepted handshake, plus per-scenario inline checks.
module tb_qspi_rx_deserializer;

  logic        h_clk = 1'b0;
  logic        h_rstn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  io_mode = 2'b00;
  logic [2:0]  num_words_m1 = 3'd0;
  logic        sample_en = 1'b0;
  logic [3:0]  io_in = 4'h0;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        send_data;
  logic        busy;
  logic        done;
  logic        overrun;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  qspi_rx_deserializer #(.DATA_W(32), .WORDS_W(3)) dut (
    .h_clk(h_clk), .h_rstn(h_rstn), .start(start), .abort(abort),
    .io_mode(io_mode), .num_words_m1(num_words_m1), .sample_en(sample_en),
    .io_in(io_in), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .send_data(send_data), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 h_clk = ~h_clk;

  // Scoreboard: every accepted word must match the oldest expected word.
  always @(negedge h_clk) begin
    if (h_rstn && rx_valid && rx_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: got word %h, none expected", rx_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (rx_data !== e) begin
          miscompares++;
          $display("FAIL sb_word: got %h expected %h", rx_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge h_clk);
    #1;
  endtask

  task automatic begin_burst(input logic [1:0] mode, input logic [2:0] nw);
    io_mode = mode;
    num_words_m1 = nw;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic sample(input logic [3:0] v);
    io_in = v;
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    tick();
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_done: done=%b after %0d cycles, required 1", name, done, n);
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle: busy=%b done=%b required 0/0", name, busy, done);
    end
  endtask

  task automatic test_reset();
    h_rstn = 1'b0;
    repeat (3) tick();
    vectors++;
    if (rx_data !== 32'h0 || rx_valid !== 1'b0 || send_data !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: data=%h valid=%b send=%b busy=%b done=%b ovr=%b required all 0",
               rx_data, rx_valid, send_data, busy, done, overrun);
    end
    h_rstn = 1'b1;
    tick();
  endtask

  task automatic test_quad_single_word();
    rx_ready = 1'b1;
    begin_burst(2'b10, 3'd0);
    exp_q.push_back(32'hAAAA_AAAA);
    vectors++;
    if (send_data !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL q1_shift: send=%b busy=%b required 1/1", send_data, busy);
    end
    for (int i = 0; i < 7; i++) sample(4'hA);
    vectors++;
    if (rx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL q1_early_valid: rx_valid=%b after 7 samples, required 0", rx_valid);
    end
    io_in = 4'hA;
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    vectors++;
    if (rx_valid !== 1'b1 || rx_data !== 32'hAAAA_AAAA || send_data !== 1'b0) begin
      miscompares++;
      $display("FAIL q1_latency: valid=%b data=%h send=%b required 1/aaaaaaaa/0",
               rx_valid, rx_data, send_data);
    end
    wait_done("q1");
  endtask

  task automatic test_quad_burst();
    logic [3:0] nib [4];
    nib[0] = 4'hA; nib[1] = 4'hC; nib[2] = 4'h3; nib[3] = 4'hC;
    rx_ready = 1'b1;
    begin_burst(2'b10, 3'd3);
    for (int w = 0; w < 4; w++) begin
      exp_q.push_back({8{nib[w]}});
      for (int s = 0; s < 8; s++) begin
        if (w == 3 && s == 7) begin
          vectors++;
          if (send_data !== 1'b1) begin
            miscompares++;
            $display("FAIL q4_window: send_data=%b before last sample, required 1", send_data);
          end
        end
        sample(nib[w]);
      end
    end
    vectors++;
    if (send_data !== 1'b0 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL q4_end: send=%b overrun=%b required 0/0", send_data, overrun);
    end
    wait_done("q4");
  endtask

  task automatic test_single();
    rx_ready = 1'b1;
    begin_burst(2'b00, 3'd0);
    exp_q.push_back(32'h5555_5555);
    for (int i = 0; i < 32; i++) sample({2'b00, logic'(i % 2), 1'b0});
    wait_done("single");
  endtask

  task automatic test_dual();
    rx_ready = 1'b1;
    begin_burst(2'b01, 3'd0);
    exp_q.push_back(32'hAAAA_AAAA);
    for (int i = 0; i < 16; i++) sample(4'b0010);
    wait_done("dual");
  endtask

  task automatic test_backpressure();
    rx_ready = 1'b0;
    begin_burst(2'b10, 3'd1);
    exp_q.push_back(32'h1111_1111);
    for (int i = 0; i < 8; i++) sample(4'h1);
    vectors++;
    if (rx_valid !== 1'b1 || rx_data !== 32'h1111_1111 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_word1: valid=%b data=%h ovr=%b required 1/11111111/0",
               rx_valid, rx_data, overrun);
    end
    for (int i = 0; i < 8; i++) sample(4'h2);
    vectors++;
    if (rx_data !== 32'h1111_1111 || overrun !== 1'b1 || send_data !== 1'b0 ||
        busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drop: data=%h ovr=%b send=%b busy=%b done=%b required 11111111/1/0/1/0",
               rx_data, overrun, send_data, busy, done);
    end
    rx_ready = 1'b1;
    wait_done("bp");
    vectors++;
    if (overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_sticky: overrun=%b required 1", overrun);
    end
  endtask

  task automatic test_abort();
    rx_ready = 1'b1;
    begin_burst(2'b10, 3'd0);
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL ab_clear_ovr: overrun=%b after start, required 0", overrun);
    end
    for (int i = 0; i < 4; i++) sample(4'hF);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b0 || rx_valid !== 1'b0 || send_data !== 1'b0) begin
      miscompares++;
      $display("FAIL ab_idle: busy=%b valid=%b send=%b required 0/0/0", busy, rx_valid, send_data);
    end
    begin_burst(2'b10, 3'd0);
    exp_q.push_back(32'h5555_5555);
    for (int i = 0; i < 8; i++) sample(4'h5);
    wait_done("ab");
  endtask

  initial begin
    test_reset();
    test_quad_single_word();
    test_quad_burst();
    test_single();
    test_dual();
    test_backpressure();
    test_abort();
    repeat (2) tick();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: %0d expected words never delivered, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
